tx_egress_arbiter: RTL and testbench

//  - Per-egress-port scheduler: shares one TX MAC byte stream among NUM_PORTS VOQ heads (one per ingress port).
//  - Frame-granular round-robin: a grant is held from first byte to voq_last; never interleaves frames.
//  - Sits between the VOQ buffers (VOQ_DEPTH frames each) and the TX MAC/CRC-append stage; byte-wide (DATA_WIDTH).

---
 rtl/tx_egress_arbiter_pkg.sv | 14 +
 rtl/tx_egress_arbiter_if.sv | 28 ++
 rtl/tx_egress_arbiter_rr_picker.sv | 28 ++
 rtl/tx_egress_arbiter.sv | 125 ++++++++++++
 tb/tb_tx_egress_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_egress_arbiter_pkg.sv
// Shared types and defaults for the TX egress arbiter slice.
package tx_egress_arbiter_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int NUM_PORTS_DEFAULT = 4;
    localparam int IFG_BYTES_DEFAULT = 12;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_IFG  = 2'd2
    } tx_arb_state_e;

endpackage

// File: rtl/tx_egress_arbiter_if.sv
// VOQ-head and TX MAC byte-stream bundle; master = arbiter, slave = VOQs/MAC side.
interface tx_egress_arbiter_if
    import tx_egress_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT,
    parameter int DW        = DATA_WIDTH
) ();

    logic [NUM_PORTS-1:0]    voq_valid;
    logic [NUM_PORTS*DW-1:0] voq_data;
    logic [NUM_PORTS-1:0]    voq_last;
    logic [NUM_PORTS-1:0]    voq_ready;
    logic                    tx_valid;
    logic [DW-1:0]           tx_data;
    logic                    tx_last;
    logic                    tx_ready;

    modport master (
        input  voq_valid, voq_data, voq_last, tx_ready,
        output voq_ready, tx_valid, tx_data, tx_last
    );

    modport slave (
        output voq_valid, voq_data, voq_last, tx_ready,
        input  voq_ready, tx_valid, tx_data, tx_last
    );

endinterface

// File: rtl/tx_egress_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_any
);

    logic w_found;
    int   w_idx;

    // Scan from the pointer; the first request seen masks all later ones.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx        = (int'(i_ptr) + k) % N;
            o_gnt[w_idx] = i_req[w_idx] & ~w_found;
            w_found      = w_found | i_req[w_idx];
        end
        o_any = w_found;
    end

endmodule

// File: rtl/tx_egress_arbiter.sv
// Frame-granular round-robin scheduler of NUM_PORTS VOQ heads onto one TX MAC byte stream.
// Define TX_ARB_IFG_EN to insert IFG_BYTES idle cycles after every frame.
module tx_egress_arbiter
    import tx_egress_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEFAULT,
    parameter int IFG_BYTES = IFG_BYTES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_egress_arbiter_if.master  bus,
    output logic [NUM_PORTS-1:0] grant_oh,
    output logic                 busy
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = $clog2(NUM_PORTS);

    localparam logic [1:0] ST_IDLE = ARB_IDLE;
    localparam logic [1:0] ST_SEND = ARB_SEND;
`ifdef TX_ARB_IFG_EN
    localparam logic [1:0] ST_IFG  = ARB_IFG;
    localparam int IW = $clog2(IFG_BYTES + 1);
    logic [IW-1:0] r_ifg_ctr;
`endif

    if (NUM_PORTS < 2 || IFG_BYTES < 1) begin : g_param_check
        $error("tx_egress_arbiter: NUM_PORTS must be >= 2 and IFG_BYTES >= 1");
    end

    logic [1:0]           r_state;
    logic [NUM_PORTS-1:0] r_grant_oh;
    logic [PW-1:0]        r_rr_ptr;

    logic [NUM_PORTS-1:0] w_pick_oh;
    logic                 w_any;
    logic [DW-1:0]        w_tx_data;
    logic                 w_tx_valid;
    logic                 w_tx_last;
    logic                 w_xfer;
    logic [PW-1:0]        w_grant_idx;
    logic [PW-1:0]        w_next_ptr;

    rr_picker #(.N(NUM_PORTS), .PW(PW)) u_picker (
        .i_req (bus.voq_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_oh),
        .o_any (w_any)
    );

    // One-hot AND-OR byte mux; a zero grant outside SEND forces everything to 0.
    always_comb begin
        w_tx_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_tx_data = w_tx_data | (bus.voq_data[i*DW +: DW] & {DW{r_grant_oh[i]}});
        end
    end

    // Encode the current owner so the pointer can move just past it.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_grant_idx = w_grant_idx | (PW'(i) & {PW{r_grant_oh[i]}});
        end
    end

    assign w_next_ptr   = (w_grant_idx == PW'(NUM_PORTS - 1)) ? '0 : w_grant_idx + PW'(1);
    assign w_tx_valid   = |(bus.voq_valid & r_grant_oh);
    assign w_tx_last    = |(bus.voq_last  & r_grant_oh);
    assign w_xfer       = w_tx_valid & bus.tx_ready;

    assign bus.tx_valid  = w_tx_valid;
    assign bus.tx_data   = w_tx_data;
    assign bus.tx_last   = w_tx_last;
    assign bus.voq_ready = r_grant_oh & {NUM_PORTS{bus.tx_ready}};
    assign grant_oh      = r_grant_oh;
    assign busy          = (r_state != ST_IDLE);

    // Arbitration FSM: the grant is held until the owner's last byte is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_oh <= '0;
            r_rr_ptr   <= '0;
`ifdef TX_ARB_IFG_EN
            r_ifg_ctr  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_oh <= w_pick_oh;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer && w_tx_last) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_grant_oh <= '0;
`ifdef TX_ARB_IFG_EN
                        r_state    <= ST_IFG;
`else
                        r_state    <= ST_IDLE;
`endif
                    end
                end
`ifdef TX_ARB_IFG_EN
                ST_IFG: begin
                    if (r_ifg_ctr == IW'(IFG_BYTES - 1)) begin
                        r_ifg_ctr <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_ifg_ctr <= r_ifg_ctr + IW'(1);
                    end
                end
`endif
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant_oh <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_egress_arbiter.sv
// Directed bench for tx_egress_arbiter; VOQs modelled as byte queues, MAC as tx_ready driver.
module tb_tx_egress_arbiter;
    import tx_egress_arbiter_pkg::*;

`ifdef TX_ARB_IFG_EN
    localparam int EXP_GAP = 13;
`else
    localparam int EXP_GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_egress_arbiter_if #(.NUM_PORTS(4), .DW(8)) ifc ();
    logic [3:0] grant_oh;
    logic       busy;

    tx_egress_arbiter #(.NUM_PORTS(4), .IFG_BYTES(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc),
        .grant_oh (grant_oh),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q_data [4][$];
    logic       q_last [4][$];
    logic       bub [4];
    logic       tx_rdy;

    logic [7:0] log_data [$];
    logic       log_last [$];
    logic [3:0] starts [$];
    logic       in_frame;
    logic [7:0] exp_data [$];
    logic       exp_last [$];

    logic       s_valid, s_last, s_busy;
    logic [7:0] s_data;
    logic [3:0] s_vready, s_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int p, input int len, input logic [7:0] base, input bit add_exp);
        for (int k = 0; k < len; k++) begin
            q_data[p].push_back(base + 8'(k));
            q_last[p].push_back(k == len - 1);
            if (add_exp) begin
                exp_data.push_back(base + 8'(k));
                exp_last.push_back(k == len - 1);
            end
        end
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_last.delete();
        starts.delete();
        exp_data.delete();
        exp_last.delete();
        in_frame = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            bub[i] = 1'b0;
        end
        clear_logs();
    endtask

    // One clock: drive VOQ heads, sample outputs, pop on the edge.
    task automatic cycle();
        logic [7:0] tmp_d;
        logic       tmp_l;
        for (int i = 0; i < 4; i++) begin
            ifc.voq_valid[i]       = (q_data[i].size() > 0) && !bub[i];
            ifc.voq_data[i*8 +: 8] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
            ifc.voq_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
        end
        ifc.tx_ready = tx_rdy;
        #1;
        s_valid  = ifc.tx_valid;
        s_last   = ifc.tx_last;
        s_data   = ifc.tx_data;
        s_vready = ifc.voq_ready;
        s_grant  = grant_oh;
        s_busy   = busy;
        if (s_valid && tx_rdy) begin
            log_data.push_back(s_data);
            log_last.push_back(s_last);
            if (!in_frame) starts.push_back(s_grant);
            in_frame = !s_last;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (s_vready[i] && ifc.voq_valid[i]) begin
                tmp_d = q_data[i].pop_front();
                tmp_l = q_last[i].pop_front();
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int c = 0;
        while (log_data.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk(tag, log_data.size(), n);
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_len"}, log_data.size(), exp_data.size());
        n = (log_data.size() < exp_data.size()) ? log_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {log_last[i], log_data[i]}, {exp_last[i], exp_data[i]});
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int bub_left;
        int gap;
        bit seen_last, got_next;
        logic [3:0] e_oh;

        tx_rdy        = 1'b1;
        in_frame      = 1'b0;
        for (int i = 0; i < 4; i++) bub[i] = 1'b0;
        ifc.voq_valid = 4'b1111;
        ifc.voq_data  = 32'h0;
        ifc.voq_last  = 4'b0000;
        ifc.tx_ready  = 1'b1;

        // Reset with every VOQ requesting
        @(negedge clk);
        #1;
        chk("rst_grant", grant_oh, 4'b0000);
        chk("rst_tx_valid", ifc.tx_valid, 1'b0);
        chk("rst_voq_ready", ifc.voq_ready, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_data", ifc.tx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Single VOQ 2, 64-byte frame
        load(2, 64, 8'h40, 1'b1);
        cycle();
        chk("t2_arb_valid", s_valid, 1'b0);
        chk("t2_arb_grant", s_grant, 4'b0000);
        cycle();
        chk("t2_grant", s_grant, 4'b0100);
        chk("t2_busy", s_busy, 1'b1);
        chk("t2_first", s_data, 8'h40);
        run_until(64, 200, "t2_count");
        cycle();
        chk("t2_grant_clr", s_grant, 4'b0000);
        check_stream("t2_stream");
        chk("t2_rr_ptr", dut.r_rr_ptr, 2'd3);

        // Four VOQs, three 4-byte frames each: strict rotation from 0
        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                load(p, 4, 8'(p * 64 + r * 16), 1'b1);
            end
        end
        run_until(48, 400, "t3_count");
        check_stream("t3_stream");
        chk("t3_nframes", starts.size(), 12);
        for (int i = 0; i < 12 && i < starts.size(); i++) begin
            e_oh = 4'b0001 << (i % 4);
            chk($sformatf("t3_order%0d", i), starts[i], e_oh);
        end

        // Back-pressure toggling plus a 3-cycle bubble on VOQ 1 with VOQ 2 waiting
        clear_logs();
        load(1, 10, 8'hA0, 1'b1);
        load(2, 4, 8'hC0, 1'b1);
        bub_left = 3;
        for (int k = 0; k < 200 && log_data.size() < 14; k++) begin
            tx_rdy = (k % 2 == 0);
            bub[1] = (q_data[1].size() == 5) && (bub_left > 0);
            if (bub[1]) bub_left--;
            cycle();
            if (bub[1]) begin
                chk("t4_bub_grant", s_grant, 4'b0010);
                chk("t4_bub_valid", s_valid, 1'b0);
            end
        end
        bub[1] = 1'b0;
        tx_rdy = 1'b1;
        chk("t4_bub_done", bub_left, 0);
        check_stream("t4_stream");
        chk("t4_nframes", starts.size(), 2);
        chk("t4_owner0", (starts.size() > 0) ? starts[0] : 4'h0, 4'b0010);
        chk("t4_owner1", (starts.size() > 1) ? starts[1] : 4'h0, 4'b0100);

        // Reset at byte 20 of a 64-byte frame on VOQ 3, VOQ 0 waiting
        clear_logs();
        load(3, 64, 8'h00, 1'b0);
        load(0, 4, 8'h80, 1'b0);
        run_until(20, 200, "t5_count");
        chk("t5_owner", (starts.size() > 0) ? starts[0] : 4'h0, 4'b1000);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", ifc.tx_valid, 1'b0);
        chk("t5_rst_grant", grant_oh, 4'b0000);
        chk("t5_rst_ready", ifc.voq_ready, 4'b0000);
        chk("t5_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        cycle();
        cycle();
        chk("t5_regrant", s_grant, 4'b0001);
        chk("t5_regrant_byte", s_data, 8'h80);

        // Back-to-back frames on VOQ 0: idle gap between them
        pulse_reset();
        load(0, 4, 8'h10, 1'b1);
        load(0, 4, 8'h20, 1'b1);
        gap = 0;
        seen_last = 1'b0;
        got_next  = 1'b0;
        for (int k = 0; k < 100 && log_data.size() < 8; k++) begin
            cycle();
            if (seen_last && !got_next) begin
                if (s_valid) got_next = 1'b1;
                else gap++;
            end
            if (s_valid && s_last && !seen_last) seen_last = 1'b1;
        end
        chk("t6_gap", gap, EXP_GAP);
        check_stream("t6_stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
